// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Function : Eight-phase fetch/execute sequencer for the 8-bit RISC CPU.
//            Decodes the 3-bit opcode and issues per-phase strobes.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       load_ir,
    output logic       load_acc,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       datactl_ena,
    output logic       halt,
    output logic       instr_done,
    output logic [2:0] phase
);

    localparam logic [2:0] c_OP_HLT  = 3'b000;
    localparam logic [2:0] c_OP_SKZ  = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_ANDD = 3'b011;
    localparam logic [2:0] c_OP_XORR = 3'b100;
    localparam logic [2:0] c_OP_LDA  = 3'b101;
    localparam logic [2:0] c_OP_STO  = 3'b110;
    localparam logic [2:0] c_OP_JMP  = 3'b111;

    typedef enum logic [3:0] {
        S0     = 4'd0,
        S1     = 4'd1,
        S2     = 4'd2,
        S3     = 4'd3,
        S4     = 4'd4,
        S5     = 4'd5,
        S6     = 4'd6,
        S7     = 4'd7,
        HALTED = 4'd8
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic w_alu_op;
    logic w_is_sto;
    logic w_is_jmp;
    logic w_skip;

    // Opcodes that read memory into the accumulator share one strobe pattern.
    assign w_alu_op = (opcode == c_OP_ADD)  || (opcode == c_OP_ANDD) ||
                      (opcode == c_OP_XORR) || (opcode == c_OP_LDA);
    assign w_is_sto = (opcode == c_OP_STO);
    assign w_is_jmp = (opcode == c_OP_JMP);
    assign w_skip   = (opcode == c_OP_SKZ) && zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        load_ir      = 1'b0;
        load_acc     = 1'b0;
        inc_pc       = 1'b0;
        load_pc      = 1'b0;
        rd           = 1'b0;
        wr           = 1'b0;
        datactl_ena  = 1'b0;
        halt         = 1'b0;
        instr_done   = 1'b0;
        phase        = r_state[2:0];

        if (r_state == HALTED) begin
            // Terminal: only the asynchronous reset leaves this state.
            w_next_state = HALTED;
            halt         = 1'b1;
            phase        = 3'd3;
        end else if (!ena) begin
            w_next_state = S0;
        end else begin
            case (r_state)
                S0: begin
                    w_next_state = S1;
                    rd           = 1'b1;
                    load_ir      = 1'b1;
                    inc_pc       = 1'b1;
                end
                S1: begin
                    w_next_state = S2;
                    rd           = 1'b1;
                    load_ir      = 1'b1;
                    inc_pc       = 1'b1;
                end
                S2: begin
                    w_next_state = S3;
                end
                S3: begin
                    if (opcode == c_OP_HLT) begin
                        w_next_state = HALTED;
                        halt         = 1'b1;
                    end else begin
                        w_next_state = S4;
                    end
                end
                S4: begin
                    w_next_state = S5;
                    rd           = w_alu_op;
                    datactl_ena  = w_is_sto;
                    load_pc      = w_is_jmp;
                end
                S5: begin
                    // JMP raises load_pc and inc_pc together; the PC favours load.
                    w_next_state = S6;
                    rd           = w_alu_op;
                    load_acc     = w_alu_op;
                    wr           = w_is_sto;
                    datactl_ena  = w_is_sto;
                    load_pc      = w_is_jmp;
                    inc_pc       = w_is_jmp || w_skip;
                end
                S6: begin
                    w_next_state = S7;
                    rd           = w_alu_op;
                    datactl_ena  = w_is_sto;
                    load_pc      = w_is_jmp;
                    inc_pc       = w_skip;
                end
                S7: begin
                    w_next_state = S0;
                    inc_pc       = w_skip;
                    instr_done   = 1'b1;
                end
                default: begin
                    w_next_state = S0;
                end
            endcase
        end

        // Outputs stay quiet for the whole reset pulse, not just after the edge.
        if (rst) begin
            load_ir     = 1'b0;
            load_acc    = 1'b0;
            inc_pc      = 1'b0;
            load_pc     = 1'b0;
            rd          = 1'b0;
            wr          = 1'b0;
            datactl_ena = 1'b0;
            halt        = 1'b0;
            instr_done  = 1'b0;
            phase       = 3'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_controller
// Function : Self-checking bench for cpu_controller (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       load_ir;
    logic       load_acc;
    logic       inc_pc;
    logic       load_pc;
    logic       rd;
    logic       wr;
    logic       datactl_ena;
    logic       halt;
    logic       instr_done;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;

    cpu_controller dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .load_ir     (load_ir),
        .load_acc    (load_acc),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .rd          (rd),
        .wr          (wr),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .instr_done  (instr_done),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output bundle: {load_ir, load_acc, inc_pc, load_pc, rd, wr,
    // datactl_ena, halt, instr_done, phase[2:0]}
    typedef struct packed {
        logic       load_ir;
        logic       load_acc;
        logic       inc_pc;
        logic       load_pc;
        logic       rd;
        logic       wr;
        logic       datactl_ena;
        logic       halt;
        logic       instr_done;
        logic [2:0] phase;
    } obs_t;

    // One instruction: per-phase masks, bit p set = strobe high in phase p.
    typedef struct {
        string      name;
        logic [2:0] op;
        logic       z;
        logic [7:0] ir;
        logic [7:0] acc;
        logic [7:0] inc;
        logic [7:0] ldpc;
        logic [7:0] rdm;
        logic [7:0] wrm;
        logic [7:0] dctl;
    } vec_t;

    vec_t tbl[9];
    obs_t sb[$];

    function automatic obs_t mk(input logic a_ir, input logic a_acc, input logic a_inc,
                                input logic a_ldpc, input logic a_rd, input logic a_wr,
                                input logic a_dctl, input logic a_halt, input logic a_done,
                                input logic [2:0] a_phase);
        obs_t o;
        o = {a_ir, a_acc, a_inc, a_ldpc, a_rd, a_wr, a_dctl, a_halt, a_done, a_phase};
        return o;
    endfunction

    task automatic check_now(input string name);
        obs_t exp_o;
        obs_t act_o;
        act_o = {load_ir, load_acc, inc_pc, load_pc, rd, wr, datactl_ena,
                 halt, instr_done, phase};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got %h", name, act_o);
        end else begin
            exp_o = sb.pop_front();
            if (act_o !== exp_o) begin
                failures++;
                $display("FAIL %s: got %h required %h (ir acc inc ldpc rd wr dctl halt done ph)",
                         name, act_o, exp_o);
            end
        end
    endtask

    // Entered just after a rising edge; inputs already driven.
    task automatic cycle(input string name, input obs_t exp_o);
        sb.push_back(exp_o);
        @(negedge clk);
        check_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic run_entry(input vec_t v, input int from, input int to);
        for (int p = from; p <= to; p++) begin
            // Opcode is don't-care while fetching, so scramble it there.
            opcode = (p < 2) ? 3'($urandom_range(0, 7)) : v.op;
            zero   = v.z;
            ena    = 1'b1;
            cycle($sformatf("%s_ph%0d", v.name, p),
                  mk(v.ir[p], v.acc[p], v.inc[p], v.ldpc[p], v.rdm[p], v.wrm[p],
                     v.dctl[p], 1'b0, (p == 7), 3'(p)));
        end
    endtask

    task automatic set_vec(input int i, input string n, input logic [2:0] op, input logic z,
                           input logic [7:0] inc, input logic [7:0] ldpc, input logic [7:0] rdm,
                           input logic [7:0] acc, input logic [7:0] wrm, input logic [7:0] dctl);
        tbl[i].name = n;
        tbl[i].op   = op;
        tbl[i].z    = z;
        tbl[i].ir   = 8'b0000_0011;
        tbl[i].inc  = inc;
        tbl[i].ldpc = ldpc;
        tbl[i].rdm  = rdm;
        tbl[i].acc  = acc;
        tbl[i].wrm  = wrm;
        tbl[i].dctl = dctl;
    endtask

    // rd and wr must never be high together.
    always @(negedge clk) begin
        if (rd && wr) begin
            checks++;
            failures++;
            $display("FAIL rd_wr_excl: rd=%b wr=%b at phase %0d", rd, wr, phase);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        //            idx name      op      z     inc           ldpc          rd            acc           wr            dctl
        set_vec(0, "add",   3'b010, 1'b0, 8'b0000_0011, 8'b0000_0000, 8'b0111_0011, 8'b0010_0000, 8'b0000_0000, 8'b0000_0000);
        set_vec(1, "andd",  3'b011, 1'b1, 8'b0000_0011, 8'b0000_0000, 8'b0111_0011, 8'b0010_0000, 8'b0000_0000, 8'b0000_0000);
        set_vec(2, "xorr",  3'b100, 1'b0, 8'b0000_0011, 8'b0000_0000, 8'b0111_0011, 8'b0010_0000, 8'b0000_0000, 8'b0000_0000);
        set_vec(3, "lda",   3'b101, 1'b0, 8'b0000_0011, 8'b0000_0000, 8'b0111_0011, 8'b0010_0000, 8'b0000_0000, 8'b0000_0000);
        set_vec(4, "sto",   3'b110, 1'b1, 8'b0000_0011, 8'b0000_0000, 8'b0000_0011, 8'b0000_0000, 8'b0010_0000, 8'b0111_0000);
        set_vec(5, "jmp",   3'b111, 1'b1, 8'b0010_0011, 8'b0111_0000, 8'b0000_0011, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
        set_vec(6, "skz_z1",3'b001, 1'b1, 8'b1110_0011, 8'b0000_0000, 8'b0000_0011, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
        set_vec(7, "skz_z0",3'b001, 1'b0, 8'b0000_0011, 8'b0000_0000, 8'b0000_0011, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
        set_vec(8, "hlt",   3'b000, 1'b0, 8'b0000_0011, 8'b0000_0000, 8'b0000_0011, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);

        rst    = 1'b1;
        ena    = 1'b1;
        opcode = 3'b010;
        zero   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back('0);
        check_now("reset_state");

        rst = 1'b0;
        for (int i = 0; i < 8; i++) run_entry(tbl[i], 0, 7);

        // Asynchronous reset in S5 of an ADD, then a clean restart.
        run_entry(tbl[0], 0, 4);
        opcode = 3'b010;
        zero   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        sb.push_back('0);
        check_now("rst_mid_s5");
        @(posedge clk);
        #1;
        sb.push_back('0);
        check_now("rst_held");
        rst = 1'b0;
        run_entry(tbl[0], 0, 7);

        // Drop ena in S4 of an ADD: strobes vanish, then a fresh fetch.
        run_entry(tbl[0], 0, 3);
        opcode = 3'b010;
        ena    = 1'b0;
        cycle("ena_drop_s4", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd4));
        run_entry(tbl[3], 0, 7);

        // HLT: halt from S3, sticky through ena toggling, cleared only by reset.
        run_entry(tbl[8], 0, 2);
        opcode = 3'b000;
        ena    = 1'b1;
        cycle("hlt_s3", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd3));
        for (int k = 0; k < 20; k++) begin
            ena    = 1'($urandom_range(0, 1));
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom_range(0, 1));
            cycle($sformatf("halted_%0d", k), mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd3));
        end
        ena = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        sb.push_back('0);
        check_now("rst_from_halted");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_entry(tbl[6], 0, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
